// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between writeback and the jal $ra link write.
// Define REGFILE_LINK_BYPASS_EN to enable the decode read bypass of pending/in-flight writes.
module regfile_write_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    input  logic             link_valid,
    input  logic [31:0]      link_pc,
    output logic             link_ready,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    input  logic [4:0]       rd_addr_a,
    input  logic [4:0]       rd_addr_b,
    output logic             byp_hit_a,
    output logic             byp_hit_b,
    output logic [31:0]      byp_data_a,
    output logic [31:0]      byp_data_b,
    output logic [CNT_W-1:0] conflict_cnt
);
    typedef enum logic {EMPTY, HELD} state_t;
    state_t state, state_next;
    logic [31:0] hold_pc;
    logic wb_eff, link_acc, capture;
    logic we_next;
    logic [4:0] waddr_next;
    logic [31:0] wdata_next;

    assign wb_eff     = wb_valid && wb_addr != 5'd0;
    assign link_ready = state == EMPTY;
    assign link_acc   = link_valid && link_ready;
    assign capture    = link_acc && wb_eff;

    always_comb begin
        state_next = state;
        we_next    = 1'b0;
        waddr_next = '0;
        wdata_next = '0;
        if (wb_eff) begin
            we_next    = 1'b1;
            waddr_next = wb_addr;
            wdata_next = wb_data;
        end
        if (state == HELD) begin
            if (!wb_eff) begin
                we_next    = 1'b1;
                waddr_next = 5'd31;
                wdata_next = hold_pc;
                state_next = EMPTY;
            end
        end else if (capture) begin
            state_next = HELD;
        end else if (link_acc) begin
            we_next    = 1'b1;
            waddr_next = 5'd31;
            wdata_next = link_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            hold_pc      <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            conflict_cnt <= '0;
        end else begin
            state    <= state_next;
            rf_we    <= we_next;
            rf_waddr <= waddr_next;
            rf_wdata <= wdata_next;
            if (capture) hold_pc <= link_pc;
            if (capture && conflict_cnt != {CNT_W{1'b1}}) conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

`ifdef REGFILE_LINK_BYPASS_EN
    // Held $ra wins over the in-flight write: it is younger than any WB issued while held.
    logic held_a, held_b, fwd_a, fwd_b;
    assign held_a     = state == HELD && rd_addr_a == 5'd31;
    assign held_b     = state == HELD && rd_addr_b == 5'd31;
    assign fwd_a      = rf_we && rf_waddr == rd_addr_a && rd_addr_a != 5'd0;
    assign fwd_b      = rf_we && rf_waddr == rd_addr_b && rd_addr_b != 5'd0;
    assign byp_hit_a  = held_a || fwd_a;
    assign byp_hit_b  = held_b || fwd_b;
    assign byp_data_a = held_a ? hold_pc : fwd_a ? rf_wdata : '0;
    assign byp_data_b = held_b ? hold_pc : fwd_b ? rf_wdata : '0;
`else
    logic unused_rd;
    assign unused_rd  = ^{rd_addr_a, rd_addr_b};
    assign byp_hit_a  = 1'b0;
    assign byp_hit_b  = 1'b0;
    assign byp_data_a = '0;
    assign byp_data_b = '0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench with a transaction-level model of the write arbiter.
module tb_regfile_write_arbiter;
    logic clk = 0, rst_n = 0;
    logic wb_valid = 0, link_valid = 0;
    logic [4:0] wb_addr = 0, rd_addr_a = 0, rd_addr_b = 0;
    logic [31:0] wb_data = 0, link_pc = 0;
    logic link_ready, rf_we, byp_hit_a, byp_hit_b;
    logic [4:0] rf_waddr;
    logic [31:0] rf_wdata, byp_data_a, byp_data_b;
    logic [7:0] conflict_cnt;

    regfile_write_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .link_valid(link_valid), .link_pc(link_pc), .link_ready(link_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .byp_hit_a(byp_hit_a), .byp_hit_b(byp_hit_b),
        .byp_data_a(byp_data_a), .byp_data_b(byp_data_b), .conflict_cnt(conflict_cnt));

    always #5 clk = ~clk;

    typedef struct packed {logic we; logic [4:0] addr; logic [31:0] data;} wr_t;
    wr_t q[$];
    wr_t m_cur;
    bit m_held;
    logic [31:0] m_pc;
    int m_cnt;
    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each cycle the registered write port must match the oldest expected slot.
    always @(posedge clk) begin
        #1;
        if (rst_n && q.size() > 0) begin
            wr_t e;
            e = q.pop_front();
            chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
            if (e.we) begin
                chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
                chk("rf_wdata", rf_wdata, e.data);
            end
        end
    end

    task automatic byp_exp(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 0;
        d = 0;
`ifdef REGFILE_LINK_BYPASS_EN
        if (a == 31 && m_held) begin hit = 1; d = m_pc; end
        else if (m_cur.we && m_cur.addr == a && a != 0) begin hit = 1; d = m_cur.data; end
`endif
    endtask

    task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [31:0] lpc);
        logic h;
        logic [31:0] d;
        wr_t e;
        bit eff, acc;
        @(negedge clk);
        chk("link_ready", {31'd0, link_ready}, {31'd0, !m_held});
        chk("conflict_cnt", {24'd0, conflict_cnt}, m_cnt);
        wb_valid = wv; wb_addr = wa; wb_data = wd; link_valid = lv; link_pc = lpc;
        rd_addr_a = ($urandom_range(0, 2) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        rd_addr_b = ($urandom_range(0, 2) == 0) ? m_cur.addr : 5'($urandom_range(0, 31));
        #1;
        byp_exp(rd_addr_a, h, d);
        chk("byp_hit_a", {31'd0, byp_hit_a}, {31'd0, h});
        chk("byp_data_a", byp_data_a, d);
        byp_exp(rd_addr_b, h, d);
        chk("byp_hit_b", {31'd0, byp_hit_b}, {31'd0, h});
        chk("byp_data_b", byp_data_b, d);
        eff = wv && wa != 0;
        acc = lv && !m_held;
        e = '0;
        if (eff) e = '{1'b1, wa, wd};
        if (m_held) begin
            if (!eff) begin e = '{1'b1, 5'd31, m_pc}; m_held = 0; end
        end else if (acc) begin
            if (eff) begin m_held = 1; m_pc = lpc; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255; end
            else e = '{1'b1, 5'd31, lpc};
        end
        q.push_back(e);
        m_cur = e;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        chk("rst rf_we", {31'd0, rf_we}, 0);
        chk("rst rf_waddr", {27'd0, rf_waddr}, 0);
        chk("rst rf_wdata", rf_wdata, 0);
        chk("rst conflict_cnt", {24'd0, conflict_cnt}, 0);
        chk("rst byp_hit_a", {31'd0, byp_hit_a}, 0);
        q.delete();
        m_held = 0; m_pc = 0; m_cnt = 0; m_cur = '0;
        wb_valid = 0; link_valid = 0;
        @(negedge clk);
        rst_n = 1;
        chk("rst link_ready", {31'd0, link_ready}, 1);
    endtask

    initial begin
        m_held = 0; m_pc = 0; m_cnt = 0; m_cur = '0;
        do_reset();
        step(1, 5, 32'h1234, 0, 0);
        idle();
        step(1, 0, 32'hdead, 1, 32'h40);
        idle();
        chk("cnt after direct link", {24'd0, conflict_cnt}, 0);
        step(1, 8, 32'haa, 1, 32'h100);
        idle();
        idle();
        chk("cnt after conflict", {24'd0, conflict_cnt}, 1);
        step(1, 9, 32'h11, 1, 32'h100);
        step(1, 31, 32'h77, 1, 32'h200);
        step(1, 10, 32'h22, 0, 0);
        step(0, 0, 0, 0, 0);
        idle();
        step(1, 12, 32'h5, 1, 32'h300);
        @(negedge clk);
        chk("held before reset", {31'd0, link_ready}, 0);
        do_reset();
        repeat (3) idle();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1, 5'($urandom_range(1, 31)), $urandom, 1, $urandom);
            idle();
        end
        @(negedge clk);
        chk("cnt saturated", {24'd0, conflict_cnt}, 255);
        do_reset();
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 1), $urandom);
        repeat (2) idle();
        @(negedge clk);
        chk("queue drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
